// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} div_state_t;

   localparam int DIV_WIDTH = 8;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
      return ~v + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/restore_sub_stage.sv
// One restoring-division trial subtract: T = R_shifted - {0,D} at WIDTH+1 bits.
module restore_sub_stage
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH:0]   R_shifted,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH:0]   T,
   output logic             take
);

   // A + ~B + 1; the top bit of the result is the borrow
   assign T    = R_shifted + ~{1'b0, D} + {{WIDTH{1'b0}}, 1'b1};
   assign take = ~T[WIDTH];

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider, one quotient bit per clock, Start/hold handshake.
// Define SIGNED_DIV_EN for two's-complement operands with a sign FIXUP cycle.
module seq_divider_8bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             DivByZero
);

   div_state_t       state, state_next;
   logic [WIDTH-1:0] d, q;
   logic [WIDTH:0]   r;
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   r_shifted, t, r_step;
   logic [WIDTH-1:0] q_step;
   logic             take, last_step;
`ifdef SIGNED_DIV_EN
   logic             sign_q, sign_r;
`endif

   assign r_shifted = {r[WIDTH-1:0], q[WIDTH-1]};

   restore_sub_stage #(.WIDTH(WIDTH)) u_sub (
      .R_shifted (r_shifted),
      .D         (d),
      .T         (t),
      .take      (take)
   );

   assign r_step    = take ? t : r_shifted;
   assign q_step    = {q[WIDTH-2:0], take};
   assign last_step = (count == CNT_W'(WIDTH - 1));

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (Start) state_next = (Divisor == {WIDTH{1'b0}}) ? DONE : ITER;
            else       state_next = IDLE;
         end
         ITER: begin
`ifdef SIGNED_DIV_EN
            if (last_step) state_next = FIXUP;
`else
            if (last_step) state_next = DONE;
`endif
            else           state_next = ITER;
         end
         FIXUP:   state_next = DONE;
         DONE: begin
            if (!Start) state_next = IDLE;
            else        state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_next;
   end

   // Status flags are registered from the next state so they line up with it
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         Busy <= 1'b0;
         Done <= 1'b0;
      end else begin
         Busy <= (state_next == ITER) || (state_next == FIXUP);
         Done <= (state_next == DONE);
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         d         <= {WIDTH{1'b0}};
         q         <= {WIDTH{1'b0}};
         r         <= {(WIDTH+1){1'b0}};
         count     <= {CNT_W{1'b0}};
         Quotient  <= {WIDTH{1'b0}};
         Remainder <= {WIDTH{1'b0}};
         DivByZero <= 1'b0;
`ifdef SIGNED_DIV_EN
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  r     <= {(WIDTH+1){1'b0}};
                  count <= {CNT_W{1'b0}};
`ifdef SIGNED_DIV_EN
                  d      <= Divisor[WIDTH-1]  ? twos_neg(Divisor)  : Divisor;
                  q      <= Dividend[WIDTH-1] ? twos_neg(Dividend) : Dividend;
                  sign_q <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                  sign_r <= Dividend[WIDTH-1];
`else
                  d <= Divisor;
                  q <= Dividend;
`endif
                  if (Divisor == {WIDTH{1'b0}}) begin
                     Quotient  <= {WIDTH{1'b1}};
                     Remainder <= Dividend;
                     DivByZero <= 1'b1;
                  end else begin
                     Quotient  <= {WIDTH{1'b0}};
                     Remainder <= {WIDTH{1'b0}};
                     DivByZero <= 1'b0;
                  end
               end
            end
            ITER: begin
               q     <= q_step;
               r     <= r_step;
               count <= count + CNT_W'(1);
`ifndef SIGNED_DIV_EN
               if (last_step) begin
                  Quotient  <= q_step;
                  Remainder <= r_step[WIDTH-1:0];
               end
`endif
            end
`ifdef SIGNED_DIV_EN
            // Magnitudes are done; restore signs (truncation toward zero)
            FIXUP: begin
               Quotient  <= sign_q ? twos_neg(q) : q;
               Remainder <= sign_r ? twos_neg(r[WIDTH-1:0]) : r[WIDTH-1:0];
            end
`endif
            DONE: begin
               if (!Start) DivByZero <= 1'b0;
            end
            default: begin
               count <= count;
            end
         endcase
      end
   end

endmodule
